// File: rtl/clk_div_prog.sv
// ---------------------------------------------------------------------------
// clk_div_prog
//
// Multi-channel programmable clock divider. Each channel counts system clock
// cycles up to its active half-period HP and toggles its divided clock on the
// terminal count, giving a 50%-duty output of period 2*(HP+1) cycles. A
// one-cycle tick strobe accompanies every rising edge of the divided clock.
//
// New half-periods are written through a shared write port. While a channel is
// running, a write is parked in a shadow register and applied only at the next
// toggle, so the half-period in progress always completes with its old value.
// A write that lands exactly on the terminal cycle is applied directly. A
// disabled channel takes the written value immediately.
//
// Ports:
//   clk_in   in   1        system clock
//   rst      in   1        asynchronous active-high reset
//   en       in   NUM_CH   per-channel run enable (0 holds channel at phase 0)
//   sync_clr in   1        synchronous phase clear of all channels
//   wr_en    in   1        half-period write strobe
//   wr_ch    in   CH_W     target channel of the write (>= NUM_CH is ignored)
//   wr_data  in   CNT_W    new half-period HP (output toggles every HP+1 cycles)
//   clk_out  out  NUM_CH   divided clocks, registered
//   tick     out  NUM_CH   one-cycle strobe, high when clk_out first reads 1
//   pending  out  NUM_CH   a written half-period awaits the next toggle
// ---------------------------------------------------------------------------
module clk_div_prog #(
    parameter int unsigned               NUM_CH = 3,
    parameter int unsigned               CNT_W  = 27,
    parameter int unsigned               CH_W   = 2,
    parameter logic [NUM_CH*CNT_W-1:0]   DEF_HP = {27'd99999999, 27'd499999, 27'd24999}
) (
    input  logic                clk_in,
    input  logic                rst,
    input  logic [NUM_CH-1:0]   en,
    input  logic                sync_clr,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [CNT_W-1:0]    wr_data,
    output logic [NUM_CH-1:0]   clk_out,
    output logic [NUM_CH-1:0]   tick,
    output logic [NUM_CH-1:0]   pending
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam logic [CNT_W-1:0] RST_HP = DEF_HP[i*CNT_W +: CNT_W];

        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] active_hp;
        logic [CNT_W-1:0] shadow_hp;
        logic             clk_q;
        logic             tick_q;
        logic             pend_q;
        logic             wr_hit;
        logic             terminal;

        // Out-of-range channel numbers never match any channel index, so such
        // writes fall through with no effect.
        assign wr_hit   = wr_en && (wr_ch == CH_W'(i));
        assign terminal = (cnt == active_hp);

        always_ff @(posedge clk_in or posedge rst) begin
            if (rst) begin
                cnt       <= '0;
                active_hp <= RST_HP;
                shadow_hp <= RST_HP;
                clk_q     <= 1'b0;
                tick_q    <= 1'b0;
                pend_q    <= 1'b0;
            end else if (sync_clr || !en[i]) begin
                // Phase clear: the next enabled cycle starts a fresh low
                // half-period. A write here cannot collide with a terminal.
                cnt    <= '0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
                if (wr_hit) begin
                    if (en[i]) begin
                        shadow_hp <= wr_data;
                        pend_q    <= 1'b1;
                    end else begin
                        // Idle channel: nothing in progress, take the value now.
                        active_hp <= wr_data;
                        shadow_hp <= wr_data;
                        pend_q    <= 1'b0;
                    end
                end
            end else if (terminal) begin
                cnt    <= '0;
                clk_q  <= ~clk_q;
                tick_q <= ~clk_q;
                if (wr_hit) begin
                    // Coincident write wins over any parked value.
                    active_hp <= wr_data;
                    shadow_hp <= wr_data;
                    pend_q    <= 1'b0;
                end else if (pend_q) begin
                    active_hp <= shadow_hp;
                    pend_q    <= 1'b0;
                end
            end else begin
                cnt    <= cnt + CNT_W'(1);
                tick_q <= 1'b0;
                if (wr_hit) begin
                    shadow_hp <= wr_data;
                    pend_q    <= 1'b1;
                end
            end
        end

        assign clk_out[i] = clk_q;
        assign tick[i]    = tick_q;
        assign pending[i] = pend_q;
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// ---------------------------------------------------------------------------
// tb_clk_div_prog
//
// Directed and randomized bench for clk_div_prog with DEF_HP = {3,1,0}.
// The reference model tracks, per channel, the absolute cycle at which the
// next toggle is due, the output level, the active/shadow half-periods and
// the pending flag.
// ---------------------------------------------------------------------------
module tb_clk_div_prog;

    localparam int unsigned DEF [3] = '{0, 1, 3};

    logic        clk_in   = 1'b0;
    logic        rst      = 1'b1;
    logic [2:0]  en       = '0;
    logic        sync_clr = 1'b0;
    logic        wr_en    = 1'b0;
    logic [1:0]  wr_ch    = '0;
    logic [26:0] wr_data  = '0;
    logic [2:0]  clk_out;
    logic [2:0]  tick;
    logic [2:0]  pending;

    int n_assert = 0;
    int n_fail   = 0;

    int unsigned edge_n = 0;
    int unsigned m_hp  [3];
    int unsigned m_sh  [3];
    int unsigned m_due [3];
    bit [2:0]    m_lvl;
    bit [2:0]    m_tk;
    bit [2:0]    m_pd;

    clk_div_prog #(
        .NUM_CH (3),
        .CNT_W  (27),
        .CH_W   (2),
        .DEF_HP ({27'd3, 27'd1, 27'd0})
    ) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .en       (en),
        .sync_clr (sync_clr),
        .wr_en    (wr_en),
        .wr_ch    (wr_ch),
        .wr_data  (wr_data),
        .clk_out  (clk_out),
        .tick     (tick),
        .pending  (pending)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, edge_n);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < 3; ch++) begin
            m_hp[ch]  = DEF[ch];
            m_sh[ch]  = DEF[ch];
            m_due[ch] = edge_n + DEF[ch] + 1;
        end
        m_lvl = '0;
        m_tk  = '0;
        m_pd  = '0;
    endtask

    // Next-toggle-time model: a channel restarted at cycle n toggles at n+HP+1,
    // and each toggle schedules the next one HP+1 cycles later using the
    // half-period in force after that toggle.
    task automatic model_edge();
        edge_n++;
        if (rst) begin
            model_reset();
            return;
        end
        for (int ch = 0; ch < 3; ch++) begin
            bit          wr;
            int unsigned d;
            wr = wr_en && (int'(wr_ch) == ch);
            d  = 32'(wr_data);
            if (sync_clr || !en[ch]) begin
                m_lvl[ch] = 1'b0;
                m_tk[ch]  = 1'b0;
                if (wr) begin
                    if (en[ch]) begin
                        m_sh[ch] = d;
                        m_pd[ch] = 1'b1;
                    end else begin
                        m_hp[ch] = d;
                        m_sh[ch] = d;
                        m_pd[ch] = 1'b0;
                    end
                end
                m_due[ch] = edge_n + m_hp[ch] + 1;
            end else if (edge_n == m_due[ch]) begin
                m_lvl[ch] = ~m_lvl[ch];
                m_tk[ch]  = m_lvl[ch];
                if (wr) begin
                    m_hp[ch] = d;
                    m_sh[ch] = d;
                    m_pd[ch] = 1'b0;
                end else if (m_pd[ch]) begin
                    m_hp[ch] = m_sh[ch];
                    m_pd[ch] = 1'b0;
                end
                m_due[ch] = edge_n + m_hp[ch] + 1;
            end else begin
                m_tk[ch] = 1'b0;
                if (wr) begin
                    m_sh[ch] = d;
                    m_pd[ch] = 1'b1;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        model_edge();
        #1;
        check3("clk_out", clk_out, m_lvl);
        check3("tick", tick, m_tk);
        check3("pending", pending, m_pd);
    endtask

    // Steps until clk_out[ch] reads lvl; returns the step count or -1 on timeout.
    task automatic steps_until(input int ch, input logic lvl, output int n);
        n = -1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (clk_out[ch] === lvl) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
        int hi [3];
        int tk [3];
        int first [3];
        int second [3];
        int n;
        int toggles;
        bit pend_seen;
        logic prev;
        int idx;

        model_reset();

        // Reset state
        repeat (2) step();
        check3("rst_clk_out", clk_out, 3'b000);
        check3("rst_pending", pending, 3'b000);

        // 1: default half-periods {3,1,0}, all channels running
        rst = 1'b0;
        en  = 3'b111;
        hi  = '{0, 0, 0};
        tk  = '{0, 0, 0};
        for (int k = 0; k < 16; k++) begin
            step();
            for (int ch = 0; ch < 3; ch++) begin
                hi[ch] += int'(clk_out[ch]);
                tk[ch] += int'(tick[ch]);
            end
        end
        check_int("t1_high0", hi[0], 8);
        check_int("t1_high1", hi[1], 8);
        check_int("t1_high2", hi[2], 8);
        check_int("t1_ticks0", tk[0], 8);
        check_int("t1_ticks1", tk[1], 4);
        check_int("t1_ticks2", tk[2], 2);

        // 2: channel 2 (HP=3) written to 1 while cnt==1
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        check3("t2_clr", clk_out, 3'b000);
        step();
        wr_en = 1'b1; wr_ch = 2'd2; wr_data = 27'd1;
        step();
        wr_en = 1'b0;
        check3("t2_pend", pending, 3'b100);
        steps_until(2, 1'b1, n);
        check_int("t2_old_half", n, 2);
        check3("t2_pend_clr", pending, 3'b000);
        steps_until(2, 1'b0, n);
        check_int("t2_new_half", n, 2);
        repeat (4) step();

        // 3: channel 1 (HP=1) written to 2 on its terminal cycle
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        step();
        wr_en = 1'b1; wr_ch = 2'd1; wr_data = 27'd2;
        step();
        wr_en = 1'b0;
        pend_seen = pending[1];
        check_int("t3_rise", int'(clk_out[1]), 1);
        steps_until(1, 1'b0, n);
        check_int("t3_new_half", n, 3);
        for (int k = 0; k < 8; k++) begin
            step();
            pend_seen |= pending[1];
        end
        check_int("t3_never_pend", int'(pend_seen), 0);

        // 4: sync_clr mid-period; HPs now {0,2,1}
        repeat (3) step();
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        check3("t4_clk_zero", clk_out, 3'b000);
        check3("t4_tick_zero", tick, 3'b000);
        first  = '{0, 0, 0};
        second = '{0, 0, 0};
        for (int k = 1; k <= 16; k++) begin
            step();
            for (int ch = 0; ch < 3; ch++) begin
                if (tick[ch] === 1'b1) begin
                    if (first[ch] == 0) first[ch] = k;
                    else if (second[ch] == 0) second[ch] = k;
                end
            end
        end
        check_int("t4_first0", first[0], 1);
        check_int("t4_first1", first[1], 3);
        check_int("t4_first2", first[2], 2);
        check_int("t4_space0", second[0] - first[0], 2);
        check_int("t4_space1", second[1] - first[1], 6);
        check_int("t4_space2", second[2] - first[2], 4);

        // 5: channel 1 disabled for 10 cycles with a write of 5 inside
        en[1] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k == 4) begin
                wr_en = 1'b1; wr_ch = 2'd1; wr_data = 27'd5;
            end else begin
                wr_en = 1'b0;
            end
            step();
        end
        wr_en = 1'b0;
        check_int("t5_held_low", int'(clk_out[1]), 0);
        check_int("t5_no_pend", int'(pending[1]), 0);
        en[1] = 1'b1;
        steps_until(1, 1'b1, n);
        check_int("t5_first_rise", n, 6);
        wr_en = 1'b1; wr_ch = 2'd3; wr_data = 27'd0;
        step();
        wr_en = 1'b0;
        check3("t5_bad_ch_pend", pending, 3'b000);
        repeat (12) step();

        // 6: channel 0 programmed to 7, then async reset between edges
        wr_en = 1'b1; wr_ch = 2'd0; wr_data = 27'd7;
        step();
        wr_en = 1'b0;
        repeat (5) step();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check3("t6_async_clk", clk_out, 3'b000);
        check3("t6_async_tick", tick, 3'b000);
        check3("t6_async_pend", pending, 3'b000);
        repeat (2) step();
        rst = 1'b0;
        toggles = 0;
        prev = clk_out[0];
        for (int k = 0; k < 8; k++) begin
            step();
            if (clk_out[0] !== prev) toggles++;
            prev = clk_out[0];
        end
        check_int("t6_def_hp0", toggles, 8);

        // Randomized traffic against the model
        for (int k = 0; k < 600; k++) begin
            sync_clr = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 15) == 0) begin
                idx = int'($urandom_range(0, 2));
                en[idx] = ~en[idx];
            end
            wr_en   = !sync_clr && ($urandom_range(0, 3) == 0);
            wr_ch   = 2'($urandom_range(0, 3));
            wr_data = 27'($urandom_range(0, 6));
            step();
        end
        sync_clr = 1'b0;
        wr_en    = 1'b0;
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Parametrised multi-channel programmable clock divider; successor to the fixed three-output divider.
- Each channel produces a 50%-duty divided clock and a one-cycle tick strobe from a single system clock.
- Each channel's half-period is runtime-programmable, glitch-free and applied only at a toggle boundary.
- Feeds display scan, key debounce and elevator floor-timer logic.

Parameters:
- NUM_CH, 3, number of divider channels (1..8).
- CNT_W, 27, counter and half-period width in bits (holds 99999999).
- CH_W, 2, width of the channel select field; must satisfy 2^CH_W >= NUM_CH.
- DEF_HP, {27'd99999999,27'd499999,27'd24999}, flat NUM_CH*CNT_W vector of reset half-periods. Channel i uses slice [i*CNT_W +: CNT_W].

Ports:
- clk_in  in  1  system clock (100 MHz nominal).
- rst  in  1  asynchronous active-high reset.
- en  in  NUM_CH  per-channel run enable.
- sync_clr  in  1  synchronous phase clear of all channels.
- wr_en  in  1  half-period write strobe.
- wr_ch  in  CH_W  target channel of the write.
- wr_data  in  CNT_W  new half-period value HP; output toggles every HP+1 clk_in cycles.
- clk_out  out  NUM_CH  divided clocks, registered.
- tick  out  NUM_CH  one-cycle strobe, registered; high in the cycle clk_out[i] first reads 1.
- pending  out  NUM_CH  a written half-period is waiting for the channel's next toggle.

Behaviour:
- Per-channel state:
  - cnt[CNT_W]
  - active_hp[CNT_W]
  - shadow_hp[CNT_W]
  - clk_out, tick, pending
- Reset (async, rst=1): cnt=0, clk_out=0, tick=0, pending=0, active_hp=shadow_hp=DEF_HP slice. Takes effect immediately regardless of clk_in.
- Run (en[i]=1, no sync_clr):
  - If cnt==active_hp (terminal): cnt<=0 and clk_out<=~clk_out. tick<=1 only when the new clk_out is 1.
  - Otherwise cnt<=cnt+1 and tick<=0.
  - Output period = 2*(HP+1) cycles, duty exactly 50%. HP=0 gives clk_in/2.
- Disabled (en[i]=0): cnt<=0, clk_out<=0, tick<=0. Re-enabling restarts from phase 0; first rising edge occurs HP+1 cycles after en rises.
- sync_clr=1: all channels cnt<=0, clk_out<=0, tick<=0 in the next cycle. Has priority over run/terminal. Does not alter active_hp, shadow_hp or pending.
- Write (wr_en=1, wr_ch<NUM_CH):
  - Channel enabled, not at terminal this cycle: shadow_hp<=wr_data, pending<=1.
  - Channel enabled, at terminal this same cycle: active_hp<=wr_data directly, pending<=0. The new value governs the next half-period.
  - Channel disabled: active_hp<=wr_data and shadow_hp<=wr_data, pending stays 0.
  - Back-to-back writes before a terminal: the last write wins.
- Pending apply: at a terminal with pending=1 and no coincident write, active_hp<=shadow_hp and pending<=0. The half-period in progress always completes with the old value, so no runt pulses.
- wr_en with wr_ch>=NUM_CH: ignored, no state change.
- Counter wrap: cnt never exceeds active_hp.
- Writing a value smaller than the current cnt is safe, because it only takes effect at a terminal.
- Channels are fully independent apart from sync_clr and the shared write port.
- No combinational path from any input to any output.

Test Plan:
1. Override DEF_HP={3,1,0}; release rst, all en=1 -> clk_out[0] toggles every cycle (period 2), [1] period 4, [2] period 8. Each tick[i] is one cycle wide and coincides with clk_out[i] reading 1; duty 50%.
2. Channel 2 running HP=3; write wr_ch=2, wr_data=1 at cnt=1 -> pending[2]=1 next cycle. Current half-period still lasts 4 cycles; thereafter half-period is 2 cycles and pending[2]=0.
3. Write on channel 1 in the exact cycle cnt==active_hp -> new HP used starting the immediately following half-period; pending[1] never asserts.
4. Assert sync_clr for 1 cycle mid-period on all channels -> all clk_out=0 and cnt=0 next cycle. Channels resume in phase, and the first ticks align at HP+1 and 2*(HP+1) spacing.
5. en[1]=0 for 10 cycles with a write of 5 during that window, then en[1]=1 -> clk_out[1] held 0 while disabled, pending[1]=0, and the first rise 6 cycles after re-enable. Also write wr_ch=3 -> no change on any channel.
6. Assert rst asynchronously between clk_in edges mid-period after programming channel 0 to 7 -> all outputs 0 immediately and channel 0 half-period back to DEF_HP value 0 after release.
